// File: rtl/line_buffer_window_ctrl_if.sv
// line_buffer_window_ctrl_if: pixel-stream handshake and window/status bundle for line_buffer_window_ctrl.
// slave = controller side, master = the stream source/sink side.
interface line_buffer_window_ctrl_if #(
   parameter int IMG_Width  = 224,
   parameter int IMG_Height = 224
);
   localparam int CW = $clog2(IMG_Width);
   localparam int RW = $clog2(IMG_Height);
   logic          Start;
   logic          In_Valid;
   logic          In_Ready;
   logic          Out_Ready;
   logic          Buf_WE;
   logic          Buf_CLR;
   logic          Win_Valid;
   logic [RW-1:0] Win_Row;
   logic [CW-1:0] Win_Col;
   logic          Busy;
   logic          Frame_Done;
   modport slave (
      input  Start, In_Valid, Out_Ready,
      output In_Ready, Buf_WE, Buf_CLR, Win_Valid, Win_Row, Win_Col, Busy, Frame_Done
   );
   modport master (
      output Start, In_Valid, Out_Ready,
      input  In_Ready, Buf_WE, Buf_CLR, Win_Valid, Win_Row, Win_Col, Busy, Frame_Done
   );
endinterface

// File: rtl/line_buffer_window_ctrl.sv
// line_buffer_window_ctrl: sequences a KxK sliding-window shift line buffer over a raster stream.
// Optional macro LBC_STRIDE2_EN: only flag windows at even offsets from the first valid position.
module line_buffer_window_ctrl #(
   parameter int IMG_Width  = 224,
   parameter int IMG_Height = 224,
   parameter int K          = 5
) (
   input logic                   CLK,
   input logic                   CLR,
   line_buffer_window_ctrl_if.slave bus
);
   localparam int CW = $clog2(IMG_Width);
   localparam int RW = $clog2(IMG_Height);
   typedef enum logic [2:0] {IDLE, FILL, STREAM, DRAIN, DONE} state_t;
   state_t        state_q, state_d;
   logic [RW-1:0] row_q, row_d, win_row_q, win_row_d;
   logic [CW-1:0] col_q, col_d, win_col_q, win_col_d;
   logic          win_valid_q, win_valid_d;
   logic          buf_clr_q, buf_clr_d;
   logic          in_ready, xfer, start_go, last_col, last_row, in_bounds, hit;
   assign in_ready  = (state_q == FILL || state_q == STREAM) && (!win_valid_q || bus.Out_Ready);
   assign xfer      = bus.In_Valid && in_ready;
   assign start_go  = state_q == IDLE && bus.Start;
   assign last_col  = col_q == CW'(IMG_Width - 1);
   assign last_row  = row_q == RW'(IMG_Height - 1);
   assign in_bounds = row_q >= RW'(K - 1) && col_q >= CW'(K - 1);
`ifdef LBC_STRIDE2_EN
   logic [RW-1:0] row_off;
   logic [CW-1:0] col_off;
   assign row_off = row_q - RW'(K - 1);
   assign col_off = col_q - CW'(K - 1);
   assign hit     = in_bounds && !row_off[0] && !col_off[0];
`else
   assign hit     = in_bounds;
`endif
   always_ff @(posedge CLK) begin
      if (!CLR) begin
         state_q     <= IDLE;
         row_q       <= '0;
         col_q       <= '0;
         win_valid_q <= 1'b0;
         win_row_q   <= '0;
         win_col_q   <= '0;
         buf_clr_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         col_q       <= col_d;
         win_valid_q <= win_valid_d;
         win_row_q   <= win_row_d;
         win_col_q   <= win_col_d;
         buf_clr_q   <= buf_clr_d;
      end
   end
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = bus.Start ? FILL : IDLE;
         FILL:    state_d = (xfer && row_q == RW'(K - 1) && col_q == CW'(K - 1)) ? STREAM : FILL;
         STREAM:  state_d = (xfer && last_col && last_row) ? DRAIN : STREAM;
         DRAIN:   state_d = win_valid_q ? DRAIN : DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   // A newly produced window outranks consumption of the previous one in the same cycle.
   always_comb begin
      col_d       = start_go ? '0 : xfer ? (last_col ? '0 : col_q + CW'(1)) : col_q;
      row_d       = start_go ? '0 : (xfer && last_col && !last_row) ? row_q + RW'(1) : row_q;
      win_valid_d = (xfer && hit) ? 1'b1 : bus.Out_Ready ? 1'b0 : win_valid_q;
      win_row_d   = (xfer && hit) ? row_q : win_row_q;
      win_col_d   = (xfer && hit) ? col_q : win_col_q;
      buf_clr_d   = !start_go;
   end
   always_comb begin
      bus.In_Ready   = in_ready;
      bus.Buf_WE     = xfer;
      bus.Buf_CLR    = buf_clr_q;
      bus.Win_Valid  = win_valid_q;
      bus.Win_Row    = win_row_q;
      bus.Win_Col    = win_col_q;
      bus.Busy       = state_q == FILL || state_q == STREAM;
      bus.Frame_Done = state_q == DONE;
   end
endmodule

// File: tb/tb_line_buffer_window_ctrl.sv
// tb_line_buffer_window_ctrl: randomized frame runs against a raster-order window model.
// Also honours LBC_STRIDE2_EN when the design is built with it.
module tb_line_buffer_window_ctrl;
   localparam int W = 8;
   localparam int H = 6;
   localparam int K = 5;
`ifdef LBC_STRIDE2_EN
   localparam bit STRIDE2 = 1'b1;
`else
   localparam bit STRIDE2 = 1'b0;
`endif
   logic clk = 1'b0;
   logic clr;
   always #5 clk = ~clk;
   line_buffer_window_ctrl_if #(.IMG_Width(W), .IMG_Height(H)) bus ();
   line_buffer_window_ctrl #(.IMG_Width(W), .IMG_Height(H), .K(K)) dut (
      .CLK(clk),
      .CLR(clr),
      .bus(bus)
   );
   int vectors = 0;
   int miscompares = 0;
   int we_cnt, fd_cnt, first_we, stall_cycles;
   bit mon_en = 1'b0;
   int got[$];
   int exp_q[$];
   always @(negedge clk) begin
      #1;
      if (mon_en) begin
         if (bus.Win_Valid && first_we < 0) first_we = we_cnt;
         if (bus.Win_Valid && bus.Out_Ready) got.push_back(int'(bus.Win_Row) * 16 + int'(bus.Win_Col));
         if (bus.Buf_WE) we_cnt++;
         if (bus.Frame_Done) fd_cnt++;
      end
   end
   task automatic build_exp();
      exp_q.delete();
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            if (r >= K - 1 && c >= K - 1 && (!STRIDE2 || ((r - K + 1) % 2 == 0 && (c - K + 1) % 2 == 0)))
               exp_q.push_back(r * 16 + c);
   endtask
   function automatic int first_diff();
      if (got.size() != exp_q.size()) return (got.size() < exp_q.size()) ? got.size() : exp_q.size();
      foreach (got[i]) if (got[i] != exp_q[i]) return i;
      return -1;
   endfunction
   task automatic run_frame(input int vpct, input int rpct, input bit stall_en, input bit start_mid,
                            output bit timeout);
      int  stall = 0;
      int  tail = 0;
      bit  stalled = 0;
      bit  pulsed = 0;
      got.delete();
      we_cnt = 0; fd_cnt = 0; first_we = -1; stall_cycles = 0;
      mon_en = 1'b1;
      @(negedge clk);
      bus.Start = 1'b1; bus.In_Valid = 1'b0; bus.Out_Ready = 1'b1;
      @(negedge clk);
      bus.Start = 1'b0;
      timeout = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         if (fd_cnt > 0) begin
            tail++;
            if (tail == 10) begin timeout = 1'b0; break; end
         end
         if (stall_en && !stalled && bus.Win_Valid && bus.Win_Row == 3'd4 && bus.Win_Col == 3'd5) begin
            stall = 5; stalled = 1'b1;
         end
         bus.Start = start_mid && !pulsed && we_cnt >= 40;
         if (bus.Start) pulsed = 1'b1;
         if (stall > 0) begin
            bus.In_Valid = 1'b1; bus.Out_Ready = 1'b0;
            #1;
            vectors++;
            if (bus.In_Ready !== 1'b0 || bus.Buf_WE !== 1'b0 || bus.Win_Row !== 3'd4 || bus.Win_Col !== 3'd5) begin
               miscompares++;
               $display("FAIL stall_hold: in_ready=%b buf_we=%b row=%0d col=%0d, required 0 0 4 5",
                        bus.In_Ready, bus.Buf_WE, bus.Win_Row, bus.Win_Col);
            end
            stall--; stall_cycles++;
         end else begin
            bus.In_Valid  = $urandom_range(99) < vpct;
            bus.Out_Ready = $urandom_range(99) < rpct;
         end
      end
      bus.Start = 1'b0; bus.In_Valid = 1'b0; bus.Out_Ready = 1'b1;
      @(negedge clk);
      mon_en = 1'b0;
   endtask
   task automatic test_reset();
      clr = 1'b0; bus.Start = 1'b1; bus.In_Valid = 1'b1; bus.Out_Ready = 1'b1;
      repeat (2) @(negedge clk);
      vectors++;
      if (bus.Buf_CLR !== 1'b0 || bus.In_Ready !== 1'b0 || bus.Win_Valid !== 1'b0 || bus.Busy !== 1'b0 ||
          bus.Frame_Done !== 1'b0 || bus.Win_Row !== 3'd0 || bus.Win_Col !== 3'd0 || bus.Buf_WE !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_state: clr=%b rdy=%b wv=%b busy=%b fd=%b row=%0d col=%0d we=%b, required all 0",
                  bus.Buf_CLR, bus.In_Ready, bus.Win_Valid, bus.Busy, bus.Frame_Done, bus.Win_Row, bus.Win_Col, bus.Buf_WE);
      end
      bus.Start = 1'b0; bus.In_Valid = 1'b0; clr = 1'b1;
      @(negedge clk);
      vectors++;
      if (bus.Buf_CLR !== 1'b1 || bus.Busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_release: buf_clr=%b busy=%b, required 1 0", bus.Buf_CLR, bus.Busy);
      end
   endtask
   task automatic check_frame(input string name, input bit timeout, input bit chk_first);
      int d;
      vectors++;
      if (timeout) begin miscompares++; $display("FAIL %s_timeout: no Frame_Done within budget", name); end
      d = first_diff();
      vectors++;
      if (d >= 0) begin
         miscompares++;
         $display("FAIL %s_windows: got %0d windows, at index %0d got %0h required %0h (of %0d)", name,
                  got.size(), d, (d < got.size()) ? got[d] : -1, (d < exp_q.size()) ? exp_q[d] : -1, exp_q.size());
      end
      vectors++;
      if (we_cnt != W * H) begin miscompares++; $display("FAIL %s_buf_we: got %0d pulses, required %0d", name, we_cnt, W * H); end
      vectors++;
      if (fd_cnt != 1) begin miscompares++; $display("FAIL %s_frame_done: got %0d pulses, required 1", name, fd_cnt); end
      if (chk_first) begin
         vectors++;
         if (first_we != (K - 1) * W + K) begin
            miscompares++;
            $display("FAIL %s_first_window: after %0d transfers, required %0d", name, first_we, (K - 1) * W + K);
         end
      end
   endtask
   task automatic test_full_frame();
      bit to;
      run_frame(100, 100, 1'b0, 1'b0, to);
      check_frame("full_frame", to, 1'b1);
   endtask
   task automatic test_stall();
      bit to;
      int exp_stall;
      run_frame(100, 100, 1'b1, 1'b0, to);
      check_frame("stall", to, 1'b1);
      exp_stall = STRIDE2 ? 0 : 5;
      vectors++;
      if (stall_cycles != exp_stall) begin
         miscompares++;
         $display("FAIL stall_seen: held %0d cycles, required %0d", stall_cycles, exp_stall);
      end
   endtask
   task automatic test_random_valid();
      bit to;
      for (int i = 0; i < 3; i++) begin
         run_frame(55, 65, 1'b0, 1'b0, to);
         check_frame("random", to, 1'b0);
      end
   endtask
   task automatic test_start_mid();
      bit to;
      run_frame(100, 100, 1'b0, 1'b1, to);
      check_frame("start_mid", to, 1'b1);
   endtask
   task automatic test_reset_mid();
      bit ok = 0;
      got.delete(); we_cnt = 0; fd_cnt = 0; first_we = -1; mon_en = 1'b1;
      @(negedge clk);
      bus.Start = 1'b1; bus.In_Valid = 1'b1; bus.Out_Ready = 1'b1;
      @(negedge clk);
      bus.Start = 1'b0;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (we_cnt >= 40) begin ok = 1; break; end
      end
      vectors++;
      if (!ok || bus.Busy !== 1'b1) begin miscompares++; $display("FAIL reset_mid_reach: transfers=%0d busy=%b, required >=40 1", we_cnt, bus.Busy); end
      clr = 1'b0;
      @(negedge clk);
      vectors++;
      if (bus.Buf_CLR !== 1'b0 || bus.In_Ready !== 1'b0 || bus.Win_Valid !== 1'b0 || bus.Busy !== 1'b0 ||
          bus.Win_Row !== 3'd0 || bus.Win_Col !== 3'd0 || bus.Frame_Done !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid_state: clr=%b rdy=%b wv=%b busy=%b row=%0d col=%0d fd=%b, required all 0",
                  bus.Buf_CLR, bus.In_Ready, bus.Win_Valid, bus.Busy, bus.Win_Row, bus.Win_Col, bus.Frame_Done);
      end
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      vectors++;
      if (bus.Buf_CLR !== 1'b1) begin miscompares++; $display("FAIL reset_mid_release: buf_clr=%b, required 1", bus.Buf_CLR); end
      repeat (20) @(negedge clk);
      vectors++;
      if (fd_cnt != 0 || bus.Busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid_no_done: frame_done=%0d busy=%b, required 0 0", fd_cnt, bus.Busy);
      end
      bus.In_Valid = 1'b0;
      mon_en = 1'b0;
   endtask
   initial begin
      build_exp();
      test_reset();
      test_full_frame();
      test_stall();
      test_random_valid();
      test_start_mid();
      test_reset_mid();
      test_full_frame();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
